// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned N x N -> 2N shift-and-add multiplier.
// The multiplier takes one bit per cycle, so a result always takes N+2
// cycles, whatever the operand values.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    begin a multiply (only accepted while idle)
//   a, b     unsigned operands, sampled when start is accepted
//   busy     high while a multiply is in flight (RUN and DONE states)
//   done     one-cycle pulse; product carries a new result
//   product  registered 2N-bit result, held until the next done
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           last_step;

    // The counter holds N-1 during the final RUN cycle.
    assign last_step = (cnt == CW'(N - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            // done/product are registered from the DONE state, so the pulse
            // lands in the cycle after DONE (N+2 cycles after acceptance).
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // Carry-out is dropped; the product can never exceed 2N bits.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    done    <= 1'b1;
                    product <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a, b;
    logic           busy, done;
    logic [2*N-1:0] product;

    int passed = 0;
    int total  = 0;

    seq_multiplier #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then watch the handshake and the result.
    task automatic run_mul(input logic [N-1:0] xa, input logic [N-1:0] xb,
                           input logic [2*N-1:0] exp, input string nm);
        int busy_cnt, done_at, done_cnt;
        logic [2*N-1:0] got;
        busy_cnt = 0; done_at = -1; done_cnt = 0; got = '0;
        a = xa; b = xb; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N + 6; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; got = product; end
            end
            tick();
        end
        total++;
        if (done_at !== N + 1 || done_cnt !== 1)
            $display("FAIL %s latency: done at %0d (count %0d), expected at %0d (count 1)", nm, done_at, done_cnt, N + 1);
        else passed++;
        total++;
        if (got !== exp) $display("FAIL %s product: got %h expected %h", nm, got, exp);
        else passed++;
        total++;
        if (busy_cnt !== N + 1) $display("FAIL %s busy cycles: got %0d expected %0d", nm, busy_cnt, N + 1);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
        tick(); tick();
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset busy/done: got %b expected 00", {busy, done});
        else passed++;
        total++;
        if (product !== 64'd0) $display("FAIL reset product: got %h expected 0", product);
        else passed++;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        run_mul(32'd123, 32'd73, 64'd8979, "basic");
    endtask

    task automatic test_boundary();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
        run_mul(32'd0, 32'hDEAD_BEEF, 64'd0, "zero");
        run_mul(32'd64, 32'd64, 64'd4096, "pow2");
        run_mul(32'd1000000000, 32'd1000000000, 64'h0DE0_B6B3_A764_0000, "large");
    endtask

    task automatic test_start_while_busy();
        int done_cnt;
        logic held_ok;
        logic [2*N-1:0] got;
        done_cnt = 0; held_ok = 1'b1; got = '0;
        a = 32'd246; b = 32'd562; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2 * N + 10; k++) begin
            if (k == 5) begin start = 1'b1; a = 32'd5; b = 32'd5; end
            if (k == 6) start = 1'b0;
            if (done) begin
                if (done_cnt == 0) got = product;
                done_cnt++;
            end else if (done_cnt == 0 && product !== 64'h0DE0_B6B3_A764_0000) begin
                held_ok = 1'b0;
            end
            tick();
        end
        total++;
        if (done_cnt !== 1) $display("FAIL busy_start done count: got %0d expected 1", done_cnt);
        else passed++;
        total++;
        if (got !== 64'd138252) $display("FAIL busy_start product: got %0d expected 138252", got);
        else passed++;
        total++;
        if (!held_ok) $display("FAIL busy_start product hold: changed before done, expected held");
        else passed++;
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        a = 32'd123; b = 32'd73; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done} !== 2'b00 || product !== 64'd0)
            $display("FAIL reset_mid state: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
        else passed++;
        for (int k = 0; k < N + 6; k++) begin
            if (done) done_cnt++;
            tick();
        end
        total++;
        if (done_cnt !== 0) $display("FAIL reset_mid spurious done: got %0d expected 0", done_cnt);
        else passed++;
        run_mul(32'd2, 32'd3, 64'd6, "after_reset");
    endtask

    task automatic test_back_to_back();
        int idx[$];
        logic prod_ok;
        prod_ok = 1'b1;
        a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        for (int k = 0; k < 3 * (N + 2) + 4; k++) begin
            if (done) begin
                idx.push_back(k);
                if (product !== 64'd63) prod_ok = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < N + 4; k++) tick();
        total++;
        if (idx.size() !== 3) $display("FAIL b2b done count: got %0d expected 3", idx.size());
        else passed++;
        total++;
        if (idx.size() < 3 || idx[0] !== N + 1 || idx[1] - idx[0] !== N + 2 || idx[2] - idx[1] !== N + 2)
            $display("FAIL b2b spacing: first=%0d count=%0d expected first %0d spacing %0d",
                     (idx.size() > 0) ? idx[0] : -1, idx.size(), N + 1, N + 2);
        else passed++;
        total++;
        if (!prod_ok) $display("FAIL b2b product: a done carried a value other than 63");
        else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
